digital_clock_ctrl: RTL and testbench
=====================================

// Module: digital_clock_ctrl
// PURPOSE
//  Run/set controller for the DigitalClock time-keeping datapath. Generates the
//  1 Hz advance enable and sequences a two-button time-set session (hours, then
//  minutes), ending in a single-cycle parallel load of H:M:00 into the counters.
//  Sits between the board buttons on io_in and the DigitalClock in the wrapper.
// PARAMETERS
//  CLK_HZ        10_000_000  clk cycles per second; prescaler period
//  DEBOUNCE_CYC  65_536      consecutive stable cycles before a button level is accepted
//  BLINK_CYC     2_500_000   clk cycles per blink half-period in set states
//  TIMEOUT_S     30          seconds with no button press before a set session aborts
// PORTS
//  clk           in   1  system clock (wb_clk_i in the wrapper)
//  reset_n       in   1  one clock; reset is asynchronous and active-low
//  btn_mode      in   1  raw async button, active-high: enter/advance/exit set mode
//  btn_inc       in   1  raw async button, active-high: increment the field being set
//  cur_hours     in   6  live hours from the datapath (0..23)
//  cur_minutes   in   6  live minutes from the datapath (0..59)
//  tick_1hz      out  1  one-cycle advance enable to the datapath
//  load          out  1  one-cycle parallel-load strobe
//  load_hours    out  6  hours value, valid while load=1
//  load_minutes  out  6  minutes value, valid while load=1
//  load_seconds  out  6  constant 0
//  set_mode      out  2  00 RUN, 01 SET_HR, 10 SET_MIN (11 never driven)
//  blink         out  1  display blink for the field being edited; 0 in RUN
// BEHAVIOUR
//  - Reset: state RUN; all outputs 0; prescaler, blink, timeout and debounce
//    counters 0; debounced levels 0; shadow regs 0. Reset during SET_*: go to RUN, no load.
//  - Buttons: 2-flop synchroniser -> debouncer. A new level is accepted after
//    DEBOUNCE_CYC consecutive equal samples. A 0->1 change of the accepted level
//    gives a one-cycle press pulse. Press latency is DEBOUNCE_CYC+3 cycles from the raw edge.
//  - Prescaler: counts 0..CLK_HZ-1 and wraps in every state. At CLK_HZ-1, sec_evt=1.
//    tick_1hz = sec_evt & (state==RUN), so time is frozen during a set session.
//  - FSM. A mode press and an inc press in the same cycle: mode wins, inc dropped.
//    RUN     --mode--> SET_HR: shadow_h<=cur_hours, shadow_m<=cur_minutes,
//                      prescaler<=0, timeout<=0
//    SET_HR  --inc-->  shadow_h <= (shadow_h>=23) ? 0 : shadow_h+1
//    SET_HR  --mode--> SET_MIN
//    SET_MIN --inc-->  shadow_m <= (shadow_m>=59) ? 0 : shadow_m+1
//    SET_MIN --mode--> RUN: load=1 for exactly that cycle; prescaler<=0, so the
//                      first tick_1hz is exactly CLK_HZ cycles after load
//    SET_*   timeout reaches TIMEOUT_S -> RUN with no load (abort; clock keeps the
//                      frozen time). Any press in SET_* clears timeout.
//  - An inc press in RUN is ignored. load and tick_1hz are never high in the same cycle.
//  - load_hours/load_minutes drive shadow_h/shadow_m continuously; sampled only when load=1.
//  - blink: toggles every BLINK_CYC cycles in SET_*; forced 0 and its counter
//    cleared in RUN; set to 1 on entry to SET_HR.
// TESTING (CLK_HZ=10, DEBOUNCE_CYC=4, BLINK_CYC=3, TIMEOUT_S=5)
//  1 Reset, idle -> tick_1hz pulses every 10 cycles; load=0; set_mode=00; blink=0.
//  2 Bounce btn_mode 1/0 each cycle for 20 cycles, then hold 1 -> exactly one press;
//    set_mode=01 DEBOUNCE_CYC+3 cycles after the final rising edge.
//  3 cur=22:58; mode, inc x3, mode, inc x2, mode -> load=1 one cycle with 01:00:00;
//    next tick_1hz 10 cycles later.
//  4 SET_MIN with btn_mode and btn_inc pressed simultaneously -> RUN with load;
//    shadow_m not incremented.
//  5 Enter SET_HR, no presses for 50 cycles -> RUN, load never asserted,
//    tick_1hz resumes.
//  6 Assert reset_n=0 mid-SET_MIN, asynchronous to clk -> all outputs 0 immediately;
//    RUN after release; no load.

Source files
------------

// File: rtl/digital_clock_ctrl.sv
// -----------------------------------------------------------------------------
// digital_clock_ctrl
// Run/set controller for the DigitalClock time-keeping datapath. Produces the
// 1 Hz advance enable and runs a two-button time-set session (hours, then
// minutes) that finishes with a one-cycle parallel load of H:M:00.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   btn_mode, btn_inc         raw asynchronous buttons, active-high
//   cur_hours, cur_minutes    live time from the datapath
//   tick_1hz                  one-cycle advance enable (RUN only)
//   load                      one-cycle parallel-load strobe
//   load_hours/minutes        edited time, valid while load=1
//   load_seconds              constant 0
//   set_mode                  00 RUN, 01 SET_HR, 10 SET_MIN
//   blink                     display blink for the field being edited
// -----------------------------------------------------------------------------
module digital_clock_ctrl #(
  parameter int unsigned CLK_HZ       = 10_000_000,
  parameter int unsigned DEBOUNCE_CYC = 65_536,
  parameter int unsigned BLINK_CYC    = 2_500_000,
  parameter int unsigned TIMEOUT_S    = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       tick_1hz,
  output logic       load,
  output logic [5:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [1:0] set_mode,
  output logic       blink
);

  localparam int unsigned PW = $clog2(CLK_HZ + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_S + 1);

  localparam int unsigned BTN_MODE = 0;
  localparam int unsigned BTN_INC  = 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  state_t              state;
  logic [1:0]          btn_raw;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          db_lvl;
  logic [1:0]          db_lvl_q;
  logic [1:0][DW-1:0]  db_cnt;
  logic [1:0]          press;
  logic                press_mode;
  logic                press_inc;
  logic                any_press;
  logic [PW-1:0]       presc;
  logic                sec_evt;
  logic [BW-1:0]       blink_cnt;
  logic [TW-1:0]       timeout_cnt;
  logic [5:0]          shadow_h;
  logic [5:0]          shadow_m;

  assign btn_raw = {btn_inc, btn_mode};

  // Synchronise and debounce both buttons; a level is accepted only after
  // DEBOUNCE_CYC consecutive samples that differ from the current level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      db_lvl   <= '0;
      db_lvl_q <= '0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
            db_lvl[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edge of the accepted level; mode wins over a coincident inc.
  assign press      = db_lvl & ~db_lvl_q;
  assign press_mode = press[BTN_MODE];
  assign press_inc  = press[BTN_INC] & ~press[BTN_MODE];
  assign any_press  = |press;

  assign sec_evt = (presc == PW'(CLK_HZ - 1));

  // Prescaler, blink, timeout and the run/set state machine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      presc       <= '0;
      tick_1hz    <= 1'b0;
      load        <= 1'b0;
      blink       <= 1'b0;
      blink_cnt   <= '0;
      timeout_cnt <= '0;
      shadow_h    <= '0;
      shadow_m    <= '0;
    end else begin
      load     <= 1'b0;
      tick_1hz <= sec_evt && (state == ST_RUN);
      presc    <= sec_evt ? '0 : presc + PW'(1);

      case (state)
        ST_RUN: begin
          blink     <= 1'b0;
          blink_cnt <= '0;
          if (press_mode) begin
            state       <= ST_SET_HR;
            shadow_h    <= cur_hours;
            shadow_m    <= cur_minutes;
            presc       <= '0;
            timeout_cnt <= '0;
            blink       <= 1'b1;
          end
        end

        ST_SET_HR, ST_SET_MIN: begin
          if (blink_cnt == BW'(BLINK_CYC - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end

          if (any_press) begin
            timeout_cnt <= '0;
          end else if (sec_evt && (timeout_cnt != TW'(TIMEOUT_S))) begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end

          if (press_mode) begin
            if (state == ST_SET_HR) begin
              state <= ST_SET_MIN;
            end else begin
              // Commit: restart the prescaler so the first tick lands a full
              // second after the load.
              state     <= ST_RUN;
              load      <= 1'b1;
              presc     <= '0;
              blink     <= 1'b0;
              blink_cnt <= '0;
            end
          end else if (timeout_cnt == TW'(TIMEOUT_S)) begin
            // Abort: datapath keeps the frozen time.
            state     <= ST_RUN;
            blink     <= 1'b0;
            blink_cnt <= '0;
          end else if (press_inc) begin
            if (state == ST_SET_HR) begin
              shadow_h <= (shadow_h >= 6'd23) ? 6'd0 : shadow_h + 6'd1;
            end else begin
              shadow_m <= (shadow_m >= 6'd59) ? 6'd0 : shadow_m + 6'd1;
            end
          end
        end

        default: begin
          state     <= ST_RUN;
          blink     <= 1'b0;
          blink_cnt <= '0;
        end
      endcase
    end
  end

  assign set_mode     = state;
  assign load_hours   = shadow_h;
  assign load_minutes = shadow_m;
  assign load_seconds = 6'd0;

endmodule

// File: tb/tb_digital_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digital_clock_ctrl
// Directed sequence with randomized session contents for digital_clock_ctrl.
// Expected times come from modular arithmetic on the requested edits.
// -----------------------------------------------------------------------------
module tb_digital_clock_ctrl;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned DEB    = 4;
  localparam int unsigned BLINK  = 3;
  localparam int unsigned TOUT   = 5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       tick_1hz;
  logic       load;
  logic [5:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic [1:0] set_mode;
  logic       blink;

  digital_clock_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DEB),
    .BLINK_CYC   (BLINK),
    .TIMEOUT_S   (TOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .cur_hours   (cur_hours),
    .cur_minutes (cur_minutes),
    .tick_1hz    (tick_1hz),
    .load        (load),
    .load_hours  (load_hours),
    .load_minutes(load_minutes),
    .load_seconds(load_seconds),
    .set_mode    (set_mode),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Event monitor sampled on the falling edge.
  int         load_cnt = 0;
  int         tick_cnt = 0;
  int         overlap_cnt = 0;
  int         long_load_cnt = 0;
  int         load_cyc = 0;
  int         tick_cyc = 0;
  int         lt_gap = -1;
  logic       lt_pend = 1'b0;
  logic       load_prev = 1'b0;
  logic [5:0] ld_h = '0;
  logic [5:0] ld_m = '0;
  logic [5:0] ld_s = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    load_prev <= load;
    if (load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      load_cyc <= cyc;
      ld_h     <= load_hours;
      ld_m     <= load_minutes;
      ld_s     <= load_seconds;
      lt_pend  <= 1'b1;
      lt_gap   <= -1;
      if (load_prev === 1'b1) long_load_cnt <= long_load_cnt + 1;
    end
    if (tick_1hz === 1'b1) begin
      tick_cnt <= tick_cnt + 1;
      tick_cyc <= cyc;
      if (load === 1'b1) begin
        overlap_cnt <= overlap_cnt + 1;
      end else if (lt_pend) begin
        lt_gap  <= cyc - load_cyc;
        lt_pend <= 1'b0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    repeat (DEB + 6) cyc1();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (DEB + 6) cyc1();
  endtask

  task automatic wait_tick(input int budget, output bit ok);
    int start;
    int n;
    start = tick_cnt;
    n = 0;
    ok = 0;
    while (!ok && n < budget) begin
      cyc1();
      n++;
      if (tick_cnt != start) ok = 1;
    end
  endtask

  task automatic wait_mode(input logic [1:0] want, input int budget, output bit ok);
    int n;
    n = 0;
    ok = (set_mode === want);
    while (!ok && n < budget) begin
      cyc1();
      n++;
      if (set_mode === want) ok = 1;
    end
  endtask

  // Hours after n increments starting from h, using the saturate-to-zero rule.
  function automatic int exp_hours(input int h, input int n);
    int v;
    v = h;
    for (int k = 0; k < n; k++) v = (v >= 23) ? 0 : v + 1;
    return v;
  endfunction

  function automatic int exp_minutes(input int m, input int n);
    int v;
    v = m;
    for (int k = 0; k < n; k++) v = (v >= 59) ? 0 : v + 1;
    return v;
  endfunction

  // Full set session: enter, nh hour incs, nm minute incs, commit.
  task automatic session(input int h, input int m, input int nh, input int nm,
                         input logic both_at_end, input string tag);
    int t_frozen;
    int l0;
    cur_hours   = 6'(h);
    cur_minutes = 6'(m);
    press(1'b1, 1'b0);
    check({tag, "_enter"}, 32'(set_mode), 32'd1);
    // Live time moving after entry must not affect the edit.
    cur_hours   = 6'($urandom_range(0, 23));
    cur_minutes = 6'($urandom_range(0, 59));
    t_frozen = tick_cnt;
    repeat (nh) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check({tag, "_setmin"}, 32'(set_mode), 32'd2);
    repeat (nm) press(1'b0, 1'b1);
    check({tag, "_frozen"}, 32'(tick_cnt), 32'(t_frozen));
    l0 = load_cnt;
    press(1'b1, both_at_end);
    repeat (4) cyc1();
    check({tag, "_loadcnt"}, 32'(load_cnt), 32'(l0 + 1));
    check({tag, "_hours"}, 32'(ld_h), 32'(exp_hours(h, nh)));
    check({tag, "_minutes"}, 32'(ld_m), 32'(exp_minutes(m, nm)));
    check({tag, "_seconds"}, 32'(ld_s), 32'd0);
    check({tag, "_run"}, 32'(set_mode), 32'd0);
    check({tag, "_tickgap"}, 32'(lt_gap), 32'(CLK_HZ));
  endtask

  initial begin
    bit ok;
    int t0;
    int l0;
    int h;
    int m;

    reset_n     = 1'b0;
    btn_mode    = 1'b0;
    btn_inc     = 1'b0;
    cur_hours   = 6'd0;
    cur_minutes = 6'd0;
    repeat (3) cyc1();

    // Reset state.
    check("rst_tick", 32'(tick_1hz), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_mode", 32'(set_mode), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_ldh", 32'(load_hours), 32'd0);
    check("rst_lds", 32'(load_seconds), 32'd0);
    reset_n = 1'b1;

    // Idle: tick every CLK_HZ cycles.
    wait_tick(2 * CLK_HZ, ok);
    check("idle_first_tick", 32'(ok), 32'd1);
    for (int k = 0; k < 3; k++) begin
      t0 = tick_cyc;
      wait_tick(2 * CLK_HZ, ok);
      check("idle_tick_period", 32'(tick_cyc - t0), 32'(CLK_HZ));
    end
    check("idle_noload", 32'(load_cnt), 32'd0);

    // Inc in RUN is ignored.
    press(1'b0, 1'b1);
    check("runinc_mode", 32'(set_mode), 32'd0);
    check("runinc_load", 32'(load_cnt), 32'd0);

    // Bounce then hold: one press, fixed latency from the final rising edge.
    cur_hours   = 6'd22;
    cur_minutes = 6'd58;
    for (int k = 0; k < 20; k++) begin
      btn_mode = (k % 2 == 0) ? 1'b1 : 1'b0;
      cyc1();
    end
    btn_mode = 1'b1;
    repeat (DEB + 2) cyc1();
    check("bounce_before", 32'(set_mode), 32'd0);
    cyc1();
    check("bounce_latency", 32'(set_mode), 32'd1);
    // Blink starts high on entry and toggles every BLINK cycles.
    for (int k = 0; k < 10; k++) begin
      check("entry_blink", 32'(blink), ((k / BLINK) % 2 == 0) ? 32'd1 : 32'd0);
      cyc1();
    end
    btn_mode = 1'b0;
    repeat (10) cyc1();
    check("bounce_single", 32'(set_mode), 32'd1);

    // 22:58 -> inc x3 hours, inc x2 minutes -> 01:00:00.
    t0 = tick_cnt;
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    check("t3_setmin", 32'(set_mode), 32'd2);
    repeat (2) press(1'b0, 1'b1);
    check("t3_frozen", 32'(tick_cnt), 32'(t0));
    l0 = load_cnt;
    press(1'b1, 1'b0);
    repeat (4) cyc1();
    check("t3_loadcnt", 32'(load_cnt), 32'(l0 + 1));
    check("t3_hours", 32'(ld_h), 32'd1);
    check("t3_minutes", 32'(ld_m), 32'd0);
    check("t3_seconds", 32'(ld_s), 32'd0);
    check("t3_tickgap", 32'(lt_gap), 32'(CLK_HZ));

    // Out-of-range live values wrap to 0 on the first increment.
    session(40, 61, 2, 1, 1'b0, "oor");

    // Randomized sessions.
    for (int s = 0; s < 3; s++) begin
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      session(h, m, $urandom_range(0, 26), $urandom_range(0, 62), 1'b0, "rnd");
    end

    // Mode and inc together in SET_MIN: commit, minute untouched.
    session($urandom_range(0, 23), $urandom_range(0, 59), 1, 3, 1'b1, "both");

    // Timeout abort.
    l0 = load_cnt;
    cur_hours   = 6'd7;
    cur_minutes = 6'd30;
    btn_mode = 1'b1;
    wait_mode(2'd1, 20, ok);
    check("to_enter", 32'(ok), 32'd1);
    repeat (5) cyc1();
    btn_mode = 1'b0;
    repeat (35) cyc1();
    check("to_still_set", 32'(set_mode), 32'd1);
    wait_mode(2'd0, 25, ok);
    check("to_abort", 32'(ok), 32'd1);
    check("to_noload", 32'(load_cnt), 32'(l0));
    wait_tick(CLK_HZ + 2, ok);
    check("to_tick_resume", 32'(ok), 32'd1);

    // Asynchronous reset in SET_MIN.
    cur_hours   = 6'd13;
    cur_minutes = 6'd45;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("ar_setmin", 32'(set_mode), 32'd2);
    check("ar_shadow", 32'(load_minutes), 32'd46);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_mode", 32'(set_mode), 32'd0);
    check("ar_blink", 32'(blink), 32'd0);
    check("ar_load", 32'(load), 32'd0);
    check("ar_tick", 32'(tick_1hz), 32'd0);
    check("ar_ldh", 32'(load_hours), 32'd0);
    check("ar_ldm", 32'(load_minutes), 32'd0);
    l0 = load_cnt;
    repeat (3) cyc1();
    reset_n = 1'b1;
    repeat (30) cyc1();
    check("ar_run", 32'(set_mode), 32'd0);
    check("ar_noload", 32'(load_cnt), 32'(l0));
    wait_tick(CLK_HZ + 2, ok);
    check("ar_tick_resume", 32'(ok), 32'd1);

    // Invariants over the whole run.
    check("load_tick_overlap", 32'(overlap_cnt), 32'd0);
    check("load_width", 32'(long_load_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
